// File: rtl/bp_be_pkg.sv
// Shared back-end types: dcache opcodes, cache-maintenance commands and sequencer states.
package bp_be_pkg;

  localparam int unsigned dword_width_gp         = 64;
  localparam int unsigned reg_addr_width_gp      = 5;
  localparam int unsigned dcache_opcode_width_gp = 5;

  typedef enum logic [4:0] {
    e_dcache_op_nop   = 5'h00,
    e_dcache_op_clean = 5'h14,
    e_dcache_op_inval = 5'h15,
    e_dcache_op_flush = 5'h16
  } bp_be_dcache_op_e;

  typedef enum logic [1:0] {
    e_cmo_clean = 2'd0,
    e_cmo_inval = 2'd1,
    e_cmo_flush = 2'd2
  } bp_be_cmo_cmd_e;

  // Encoding 3 is accepted on the command port and silently dropped.
  localparam logic [1:0] cmo_cmd_reserved_gp = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } bp_be_cmo_state_e;

  function automatic int unsigned bp_be_dcache_pkt_width(input int unsigned vaddr_width);
    return dcache_opcode_width_gp + dword_width_gp + reg_addr_width_gp + vaddr_width;
  endfunction

  function automatic bp_be_dcache_op_e bp_be_cmo_to_dcache_op(input bp_be_cmo_cmd_e cmd);
    bp_be_dcache_op_e op;
    case (cmd)
      e_cmo_clean: op = e_dcache_op_clean;
      e_cmo_inval: op = e_dcache_op_inval;
      default:     op = e_dcache_op_flush;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/bp_be_credit_counter.sv
// Up/down saturating credit counter with full/empty flags.
module bp_be_credit_counter #(
  parameter int unsigned max_p  = 4,
  parameter int unsigned init_p = max_p,
  localparam int unsigned width_lp = $clog2(max_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [width_lp-1:0] count_o,
  output logic                full_o,
  output logic                empty_o
);

  logic [width_lp-1:0] count_q, count_d;

  assign count_o = count_q;
  assign full_o  = (count_q == width_lp'(max_p));
  assign empty_o = (count_q == '0);

  always_comb begin
    count_d = count_q;
    unique case ({inc_i, dec_i})
      2'b10:   if (!full_o)  count_d = count_q + width_lp'(1);
      2'b01:   if (!empty_o) count_d = count_q - width_lp'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) count_q <= width_lp'(init_p);
    else            count_q <= count_d;
  end

  // Returning a credit that was never taken indicates a broken credit loop.
  inc_when_full_a : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(inc_i && full_o));

endmodule

// File: rtl/bp_be_dcache_cmo_sequencer.sv
// Walks every dcache set/way issuing clean/inval/flush packets under a credit limit.
module bp_be_dcache_cmo_sequencer
  import bp_be_pkg::*;
#(
  parameter int unsigned sets_p        = 64,
  parameter int unsigned assoc_p       = 8,
  parameter int unsigned block_width_p = 512,
  parameter int unsigned vaddr_width_p = 39,
  parameter int unsigned credits_p     = 4,
  localparam int unsigned pkt_width_lp = bp_be_dcache_pkt_width(vaddr_width_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    cmd_v_i,
  input  logic [1:0]              cmd_i,
  output logic                    cmd_ready_o,
  output logic                    pkt_v_o,
  output logic [pkt_width_lp-1:0] pkt_o,
  input  logic                    pkt_ready_i,
  input  logic                    ack_v_i,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int unsigned lines_lp        = sets_p * assoc_p;
  localparam int unsigned idx_width_lp    = $clog2(lines_lp);
  localparam int unsigned offset_lp       = $clog2(block_width_p / 8);
  localparam int unsigned credit_width_lp = $clog2(credits_p + 1);

  typedef struct packed {
    bp_be_dcache_op_e               opcode;
    logic [dword_width_gp-1:0]      data;
    logic [reg_addr_width_gp-1:0]   rd_addr;
    logic [vaddr_width_p-1:0]       vaddr;
  } bp_be_dcache_pkt_s;

  bp_be_cmo_state_e          state_q;
  logic [idx_width_lp-1:0]   idx_q;
  bp_be_dcache_op_e          op_q;
  logic [credit_width_lp-1:0] credits;
  logic                      credits_full, credits_empty;
  logic                      pkt_hs, drain_done;
  bp_be_dcache_pkt_s         pkt;

  bp_be_credit_counter #(
    .max_p  (credits_p),
    .init_p (credits_p)
  ) u_credits (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .inc_i     (ack_v_i),
    .dec_i     (pkt_hs),
    .count_o   (credits),
    .full_o    (credits_full),
    .empty_o   (credits_empty)
  );

  assign pkt_v_o = (state_q == StIssue) && !credits_empty;
  assign pkt_hs  = pkt_v_o && pkt_ready_i;

  // Drain completes on the ack that refills the counter, not a cycle later.
  assign drain_done = credits_full ||
                      (ack_v_i && (credits == credit_width_lp'(credits_p - 1)));

  assign cmd_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StDone);

  // idx is {way, set}, so shifting it past the block offset yields both fields in place.
  always_comb begin
    pkt        = '0;
    pkt.opcode = op_q;
    pkt.vaddr  = vaddr_width_p'(idx_q) << offset_lp;
  end
  assign pkt_o = pkt;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      op_q    <= e_dcache_op_nop;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_v_i && (cmd_i != cmo_cmd_reserved_gp)) begin
            op_q    <= bp_be_cmo_to_dcache_op(bp_be_cmo_cmd_e'(cmd_i));
            idx_q   <= '0;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (pkt_hs) begin
            idx_q <= idx_q + idx_width_lp'(1);
            if (idx_q == idx_width_lp'(lines_lp - 1)) state_q <= StDrain;
          end
        end
        StDrain: if (drain_done) state_q <= StDone;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_be_dcache_cmo_sequencer.sv
// Randomized bench for the dcache maintenance sequencer against a counting reference model.
module tb_bp_be_dcache_cmo_sequencer;
  import bp_be_pkg::*;

  localparam int Sets    = 4;
  localparam int Assoc   = 2;
  localparam int Credits = 2;
  localparam int Lines   = Sets * Assoc;
  localparam int Offset  = 6;
  localparam int VaddrW  = 39;
  localparam int PktW    = 5 + 64 + 5 + VaddrW;

  logic            clk_i = 1'b0;
  logic            reset_n_i;
  logic            cmd_v_i;
  logic [1:0]      cmd_i;
  logic            cmd_ready_o;
  logic            pkt_v_o;
  logic [PktW-1:0] pkt_o;
  logic            pkt_ready_i;
  logic            ack_v_i;
  logic            busy_o;
  logic            done_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  bp_be_dcache_cmo_sequencer #(
    .sets_p        (Sets),
    .assoc_p       (Assoc),
    .block_width_p (512),
    .vaddr_width_p (VaddrW),
    .credits_p     (Credits)
  ) dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .cmd_v_i     (cmd_v_i),
    .cmd_i       (cmd_i),
    .cmd_ready_o (cmd_ready_o),
    .pkt_v_o     (pkt_v_o),
    .pkt_o       (pkt_o),
    .pkt_ready_i (pkt_ready_i),
    .ack_v_i     (ack_v_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] exp_opcode(input logic [1:0] c);
    case (c)
      2'd0:    return e_dcache_op_clean;
      2'd1:    return e_dcache_op_inval;
      default: return e_dcache_op_flush;
    endcase
  endfunction

  // Line n of the walk: set = n mod Sets, way = n div Sets.
  function automatic logic [VaddrW-1:0] model_addr(input int n);
    int s, w;
    s = n % Sets;
    w = n / Sets;
    return VaddrW'((s << Offset) + (w << (Offset + $clog2(Sets))));
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 64'(cmd_ready_o), 1);
    check({tag, "_pkt_v"}, 64'(pkt_v_o), 0);
    check({tag, "_busy"},  64'(busy_o), 0);
    check({tag, "_done"},  64'(done_o), 0);
  endtask

  // Called at a sample point; ack_mode 0 = 1-cycle acks, 1 = random delay, 2 = withheld.
  task automatic run_op(input logic [1:0] cmd, input int ready_pct, input int ack_mode,
                        input int abort_at, input bit hold, input logic [1:0] next_cmd);
    int  issued, acked, pkt_seen, cyc, last_due, due;
    bit  exp_v, exp_done_now, exp_done_next, finished;
    int  ackq[$];
    logic [4:0] exp_op;
    exp_op = exp_opcode(cmd);
    issued = 0; acked = 0; pkt_seen = 0; cyc = 0; last_due = 0;
    exp_done_now = 0; finished = 0;
    cmd_v_i = 1'b1; cmd_i = cmd; ack_v_i = 1'b0; pkt_ready_i = 1'b0;
    check("accept_ready", 64'(cmd_ready_o), 1);
    check("accept_busy", 64'(busy_o), 0);
    @(posedge clk_i); #1;
    cmd_v_i = hold;
    cmd_i   = hold ? next_cmd : 2'd0;
    while (!finished && cyc < 400) begin
      check("busy", 64'(busy_o), 1);
      check("cmd_ready_busy", 64'(cmd_ready_o), 0);
      check("done", 64'(done_o), 64'(exp_done_now));
      exp_v = (issued < Lines) && ((issued - acked) < Credits);
      check("pkt_v", 64'(pkt_v_o), 64'(exp_v));
      if (pkt_v_o && exp_v) begin
        check("opcode",  64'(pkt_o[PktW-1 -: 5]), 64'(exp_op));
        check("vaddr",   64'(pkt_o[VaddrW-1:0]), 64'(model_addr(issued)));
        check("rd_addr", 64'(pkt_o[VaddrW+4:VaddrW]), 0);
        check("data",    pkt_o[VaddrW+68:VaddrW+5], 0);
      end
      if (exp_done_now) begin
        finished = 1;
      end else if (abort_at >= 0 && issued == abort_at) begin
        pkt_ready_i = 1'b0;
        ack_v_i     = 1'b0;
        return;
      end else begin
        pkt_ready_i   = (int'($urandom_range(0, 99)) < ready_pct);
        exp_done_next = 0;
        if (ackq.size() > 0 && ackq[0] <= cyc) begin
          ack_v_i = 1'b1;
          void'(ackq.pop_front());
          acked++;
          exp_done_next = (acked == Lines);
        end else begin
          ack_v_i = 1'b0;
        end
        if (pkt_v_o && pkt_ready_i) pkt_seen++;
        if (exp_v && pkt_ready_i) begin
          issued++;
          case (ack_mode)
            0:       due = cyc + 1;
            1:       due = cyc + int'($urandom_range(1, 4));
            default: due = cyc + 5;
          endcase
          if (ack_mode == 2 && due < last_due + 3) due = last_due + 3;
          if (due < last_due) due = last_due;
          last_due = due;
          ackq.push_back(due);
        end
        @(posedge clk_i); #1;
        cyc++;
        exp_done_now = exp_done_next;
      end
    end
    if (!finished) check("timeout", 0, 1);
    ack_v_i = 1'b0;
    pkt_ready_i = 1'b0;
    @(posedge clk_i); #1;
    check("busy_after", 64'(busy_o), 0);
    check("done_after", 64'(done_o), 0);
    check("ready_after", 64'(cmd_ready_o), 1);
    check("pkt_v_after", 64'(pkt_v_o), 0);
    check("pkt_count", 64'(pkt_seen), Lines);
  endtask

  initial begin
    reset_n_i = 1'b0; cmd_v_i = 1'b0; cmd_i = 2'd0; pkt_ready_i = 1'b0; ack_v_i = 1'b0;
    #1;
    check_idle_outputs("reset");
    @(negedge clk_i); @(negedge clk_i);
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    check_idle_outputs("post_reset");

    run_op(2'd2, 100, 0, -1, 1'b0, 2'd0);
    run_op(2'd0, 100, 2, -1, 1'b0, 2'd0);
    run_op(2'd1, 50, 1, -1, 1'b0, 2'd0);

    // Reserved command is accepted and dropped.
    cmd_v_i = 1'b1; cmd_i = 2'd3;
    check("rsvd_ready", 64'(cmd_ready_o), 1);
    @(posedge clk_i); #1;
    cmd_v_i = 1'b0; cmd_i = 2'd0;
    repeat (4) begin
      check_idle_outputs("rsvd");
      @(posedge clk_i); #1;
    end

    // Abandon a walk with an asynchronous reset after three packets.
    run_op(2'd0, 100, 0, 3, 1'b0, 2'd0);
    cmd_v_i = 1'b0;
    #2 reset_n_i = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    run_op(2'd0, 100, 0, -1, 1'b0, 2'd0);

    // Command held high across a walk; the queued one is taken right after done.
    run_op(2'd2, 100, 1, -1, 1'b1, 2'd1);
    run_op(2'd1, 70, 1, -1, 1'b0, 2'd0);

    for (int k = 0; k < 4; k++) begin
      run_op(2'($urandom_range(0, 2)), int'($urandom_range(30, 100)),
             int'($urandom_range(0, 2)), -1, 1'b0, 2'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
